// File: rtl/renas_ahb_pkg.sv
// Shared AHB-lite bus types and constants for the renas arbiter and its winner-select helper.
package renas_ahb_pkg;

  localparam int HADDR_W = 32;
  localparam int HDATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [HADDR_W-1:0] haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [2:0]         hsize;
    logic [2:0]         hburst;
    logic [3:0]         hprot;
    logic               hmastlock;
    logic [HDATA_W-1:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic [HDATA_W-1:0] hrdata;
    logic               hready;
    logic               hresp;
  } slv_send_type;

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  function automatic logic is_req(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/renas_arb_pick.sv
// Combinational winner select: fixed priority (ties to lowest index) or round-robin after rr_ptr.
module renas_arb_pick
  import renas_ahb_pkg::*;
#(
  parameter int        N_MASTER = 3,
  parameter int        PRIO_W   = 2,
  parameter arb_mode_e MODE     = ARB_FIXED,
  localparam int       IDX_W    = $clog2(N_MASTER)
) (
  input  logic [N_MASTER-1:0]             req,
  input  logic [N_MASTER-1:0][PRIO_W-1:0] hprior,
  input  logic [IDX_W-1:0]                rr_ptr,
  output logic [IDX_W-1:0]                winner,
  output logic                            any_req
);

  logic [IDX_W-1:0]  fp_win;
  logic [IDX_W-1:0]  rr_win;
  logic [PRIO_W-1:0] best;
  logic              fp_found;
  logic              rr_found;
  int                idx;

  always_comb begin
    fp_win   = '0;
    fp_found = 1'b0;
    best     = '0;
    // Strict greater-than keeps the lowest index on equal priority.
    for (int i = 0; i < N_MASTER; i++) begin
      if (req[i] && (!fp_found || hprior[i] > best)) begin
        fp_found = 1'b1;
        best     = hprior[i];
        fp_win   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_MASTER; k++) begin
      idx = (int'(rr_ptr) + k) % N_MASTER;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_win   = IDX_W'(idx);
      end
    end
  end

  assign winner  = (MODE == ARB_RR) ? rr_win : fp_win;
  assign any_req = |req;

endmodule

// File: rtl/renas_ahb_arbiter.sv
// N-master to 1-slave AHB-lite arbiter/mux with burst/lock retention and a separate data-phase owner.
module renas_ahb_arbiter
  import renas_ahb_pkg::*;
#(
  parameter int  N_MASTER    = 3,
  parameter int  PRIO_W      = 2,
  parameter int  ARB_MODE    = 0,
  parameter int  PARK_MASTER = 0,
  localparam int IDX_W       = $clog2(N_MASTER)
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  mas_send_type                    master_in [N_MASTER],
  input  logic [N_MASTER-1:0][PRIO_W-1:0] hprior,
  output slv_send_type                    master_out [N_MASTER],
  output mas_send_type                    slave_out,
  input  slv_send_type                    slave_in,
  output logic [IDX_W-1:0]                hmaster,
  output logic [IDX_W-1:0]                hmaster_data
);

  localparam arb_mode_e        MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;
  localparam logic [IDX_W-1:0] PARK = IDX_W'(PARK_MASTER);

  logic [IDX_W-1:0]    addr_owner;
  logic [IDX_W-1:0]    data_owner;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic [N_MASTER-1:0] req;
  logic                any_req;
  logic                owner_free;
  logic                do_switch;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_MASTER; i++) req[i] = is_req(master_in[i].htrans);
  end

  renas_arb_pick #(
    .N_MASTER (N_MASTER),
    .PRIO_W   (PRIO_W),
    .MODE     (MODE)
  ) u_pick (
    .req     (req),
    .hprior  (hprior),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Owner must be truly IDLE (not BUSY) and unlocked, so bursts and locked sequences stay intact.
  assign owner_free = (master_in[addr_owner].htrans == HTRANS_IDLE) &&
                      !master_in[addr_owner].hmastlock;
  assign do_switch  = slave_in.hready && owner_free && any_req;

  always_comb begin
    slave_out        = master_in[addr_owner];
    slave_out.hwdata = master_in[data_owner].hwdata;
  end

  // Requesting non-owners see hready low and hold their address phase.
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      master_out[i].hrdata = slave_in.hrdata;
      master_out[i].hresp  = slave_in.hresp;
      master_out[i].hready = (IDX_W'(i) == addr_owner) ? slave_in.hready
                                                       : (master_in[i].htrans == HTRANS_IDLE);
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      addr_owner <= PARK;
      data_owner <= PARK;
      rr_ptr     <= PARK;
    end else begin
      if (slave_in.hready) data_owner <= addr_owner;
      if (do_switch) begin
        addr_owner <= winner;
        rr_ptr     <= winner;
      end
    end
  end

  assign hmaster      = addr_owner;
  assign hmaster_data = data_owner;

endmodule
